// File: rtl/fir_transpose_cfg.sv
// Runtime-programmable transposed-form FIR: valid-qualified samples, coefficient write port,
// round-half-up scaling, saturating output with sticky flag, and a history-preserving bypass.
module fir_transpose_cfg #(
    parameter int unsigned WD_IN   = 24,
    parameter int unsigned WD_OUT  = 24,
    parameter int unsigned WD_COEF = 16,
    parameter int unsigned TAPS    = 16,
    parameter int unsigned FRAC    = 15
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic signed [WD_IN-1:0]   data_in,
    input  logic                      in_valid,
    output logic signed [WD_OUT-1:0]  data_out,
    output logic                      out_valid,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [WD_COEF-1:0] coef_data,
    input  logic                      bypass,
    output logic                      sat_flag,
    input  logic                      sat_clr
);
    localparam int unsigned AW      = $clog2(TAPS);
    localparam int unsigned WD_PROD = WD_IN + WD_COEF;
    localparam int unsigned WD_ACC  = WD_PROD + $clog2(TAPS);

    localparam logic signed [WD_ACC-1:0] ROUND   = WD_ACC'(1) << (FRAC - 1);
    localparam logic signed [WD_ACC-1:0] OUT_MAX = {{(WD_ACC - WD_OUT + 1){1'b0}}, {(WD_OUT - 1){1'b1}}};
    localparam logic signed [WD_ACC-1:0] OUT_MIN = {{(WD_ACC - WD_OUT + 1){1'b1}}, {(WD_OUT - 1){1'b0}}};

    logic signed [WD_COEF-1:0] h [TAPS];
    logic signed [WD_ACC-1:0]  z [1:TAPS-1];
    logic signed [WD_PROD-1:0] p [TAPS];
    logic signed [WD_ACC-1:0]  acc;
    logic signed [WD_ACC-1:0]  acc_rnd;
    logic signed [WD_ACC-1:0]  r;
    logic signed [WD_ACC-1:0]  x_ext;
    logic signed [WD_OUT-1:0]  filt_val;
    logic signed [WD_OUT-1:0]  byp_val;
    logic                      filt_ovf;

    function automatic logic over_range(input logic signed [WD_ACC-1:0] v);
        return (v > OUT_MAX) || (v < OUT_MIN);
    endfunction

    function automatic logic signed [WD_OUT-1:0] clip(input logic signed [WD_ACC-1:0] v);
        if (v > OUT_MAX)      return OUT_MAX[WD_OUT-1:0];
        else if (v < OUT_MIN) return OUT_MIN[WD_OUT-1:0];
        else                  return v[WD_OUT-1:0];
    endfunction

    // Products, output tap sum, rounding and clamping for the current sample
    always_comb begin
        for (int unsigned k = 0; k < TAPS; k++) begin
            p[k] = data_in * h[k];
        end
        acc      = WD_ACC'(p[0]) + z[1];
        acc_rnd  = acc + ROUND;
        r        = acc_rnd >>> FRAC;
        x_ext    = WD_ACC'(data_in);
        filt_ovf = over_range(r);
        filt_val = clip(r);
        byp_val  = clip(x_ext);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                h[k] <= '0;
            end
            for (int unsigned k = 1; k < TAPS; k++) begin
                z[k] <= '0;
            end
            data_out  <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            // Same-cycle sample still sees the old coefficient through p[]
            for (int unsigned k = 0; k < TAPS; k++) begin
                if (coef_we && coef_addr == AW'(k)) begin
                    h[k] <= coef_data;
                end
            end
            // History advances even in bypass so leaving bypass needs no flush
            if (in_valid) begin
                for (int unsigned k = 1; k < TAPS - 1; k++) begin
                    z[k] <= WD_ACC'(p[k]) + z[k+1];
                end
                z[TAPS-1] <= WD_ACC'(p[TAPS-1]);
                data_out  <= bypass ? byp_val : filt_val;
            end
            if (in_valid && !bypass && filt_ovf) begin
                sat_flag <= 1'b1;
            end else if (sat_clr) begin
                sat_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_transpose_cfg.sv
// Bench for fir_transpose_cfg: direct-form product-history model feeding a scoreboard,
// hand-derived vector tables for impulse/rounding, plus saturation, bypass and reset sequences.
module tb_fir_transpose_cfg;
    localparam int WD_IN   = 24;
    localparam int WD_OUT  = 24;
    localparam int WD_COEF = 16;
    localparam int TAPS    = 16;
    localparam int FRAC    = 15;
    localparam int AW      = $clog2(TAPS);
    localparam longint OMAX = (longint'(1) <<< (WD_OUT - 1)) - 1;
    localparam longint OMIN = -(longint'(1) <<< (WD_OUT - 1));

    typedef struct { longint x; longint y; } vec_t;
    typedef struct { longint data; bit sat; } exp_t;

    logic                      clk       = 1'b0;
    logic                      reset_n   = 1'b0;
    logic signed [WD_IN-1:0]   data_in   = '0;
    logic                      in_valid  = 1'b0;
    logic signed [WD_OUT-1:0]  data_out;
    logic                      out_valid;
    logic                      coef_we   = 1'b0;
    logic [AW-1:0]             coef_addr = '0;
    logic signed [WD_COEF-1:0] coef_data = '0;
    logic                      bypass    = 1'b0;
    logic                      sat_flag;
    logic                      sat_clr   = 1'b0;

    fir_transpose_cfg #(
        .WD_IN(WD_IN), .WD_OUT(WD_OUT), .WD_COEF(WD_COEF), .TAPS(TAPS), .FRAC(FRAC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .in_valid(in_valid),
        .data_out(data_out), .out_valid(out_valid), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .bypass(bypass),
        .sat_flag(sat_flag), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    string  tag   = "init";
    exp_t   sb[$];
    longint mh[TAPS];
    longint pv[TAPS][TAPS];
    bit     msat;
    longint last_data;
    vec_t   imp[21];
    vec_t   rnd[4];

    task automatic chk(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s/%s: got %0d want %0d", tag, name, got, want);
        end
    endtask

    function automatic longint clip(input longint v);
        if (v > OMAX) return OMAX;
        if (v < OMIN) return OMIN;
        return v;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < TAPS; k++) begin
            mh[k] = 0;
            for (int d = 0; d < TAPS; d++) pv[d][k] = 0;
        end
        msat      = 1'b0;
        last_data = 0;
    endfunction

    // pv[d][k] = product of the sample d steps ago with the h[k] in force at that time
    function automatic longint model_sample(input longint x, input bit byp, output bit ev);
        longint acc;
        longint r;
        acc = 0;
        for (int d = TAPS - 1; d > 0; d--) pv[d] = pv[d-1];
        for (int k = 0; k < TAPS; k++) pv[0][k] = x * mh[k];
        for (int d = 0; d < TAPS; d++) acc += pv[d][d];
        r = (acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        if (byp) begin
            ev = 1'b0;
            return clip(x);
        end
        ev = (r > OMAX) || (r < OMIN);
        return clip(r);
    endfunction

    task automatic cycle(input bit v, input longint x, input bit byp, input bit clr,
                         input bit we, input int wa, input longint wd,
                         input bit use_hand, input longint hand);
        exp_t   e;
        bit     ev;
        longint y;
        ev        = 1'b0;
        in_valid  = v;
        data_in   = WD_IN'(x);
        bypass    = byp;
        sat_clr   = clr;
        coef_we   = we;
        coef_addr = AW'(wa);
        coef_data = WD_COEF'(wd);
        if (v) y = model_sample(x, byp, ev);
        if (ev) msat = 1'b1;
        else if (clr) msat = 1'b0;
        if (v) begin
            e.data = use_hand ? hand : y;
            e.sat  = msat;
            sb.push_back(e);
        end
        if (we && wa < TAPS) mh[wa] = wd;
        @(posedge clk);
        #1;
        chk("out_valid", longint'(out_valid), longint'(v));
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("pending", longint'(sb.size()), 1);
            end else begin
                e = sb.pop_front();
                last_data = e.data;
                chk("data", longint'(data_out), e.data);
                chk("sat", longint'(sat_flag), longint'(e.sat));
            end
        end else begin
            chk("hold", longint'(data_out), last_data);
            chk("sat_hold", longint'(sat_flag), longint'(msat));
        end
        in_valid = 1'b0;
        coef_we  = 1'b0;
        sat_clr  = 1'b0;
        bypass   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int a, input longint d);
        cycle(0, 0, 0, 0, 1, a, d, 0, 0);
    endtask

    task automatic smp(input longint x, input bit byp);
        cycle(1, x, byp, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic smp_h(input longint x, input bit byp, input longint y);
        cycle(1, x, byp, 0, 0, 0, 0, 1, y);
    endtask

    initial begin
        imp[0].x = 32768;
        imp[0].y = 1;
        for (int i = 1; i < 21; i++) begin
            imp[i].x = 0;
            imp[i].y = (i < TAPS) ? longint'(i + 1) : 0;
        end
        rnd[0].x = 3;  rnd[0].y = 2;
        rnd[1].x = -3; rnd[1].y = -1;
        rnd[2].x = 1;  rnd[2].y = 1;
        rnd[3].x = -1; rnd[3].y = 0;
        model_reset();

        tag = "reset";
        #12;
        chk("data_out", longint'(data_out), 0);
        chk("out_valid", longint'(out_valid), 0);
        chk("sat_flag", longint'(sat_flag), 0);
        reset_n = 1'b1;

        tag = "impulse";
        for (int k = 0; k < TAPS; k++) wr(k, k + 1);
        for (int i = 0; i < 21; i++) smp_h(imp[i].x, 0, imp[i].y);

        tag = "gaps";
        for (int i = 0; i < 21; i++) begin
            if (i == 0) cycle(1, imp[0].x, 0, 0, 1, 0, 0, 1, imp[0].y);
            else smp_h(imp[i].x, 0, imp[i].y);
            idle(3);
        end

        tag = "bypass";
        wr(0, 1);
        smp_h(32768, 1, 32768);
        smp_h(0, 1, 0);
        for (int i = 2; i < 21; i++) smp_h(0, 0, imp[i].y);

        tag = "round";
        wr(0, 16384);
        for (int k = 1; k < TAPS; k++) wr(k, 0);
        for (int i = 0; i < 4; i++) smp_h(rnd[i].x, 0, rnd[i].y);

        tag = "sat_pos";
        for (int k = 0; k < TAPS; k++) wr(k, 32767);
        repeat (19) smp(8388607, 0);
        smp_h(8388607, 0, OMAX);
        chk("flag_set", longint'(sat_flag), 1);
        idle(2);
        cycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("flag_clr", longint'(sat_flag), 0);

        tag = "sat_byp";
        smp_h(8388607, 1, 8388607);
        chk("flag_byp", longint'(sat_flag), 0);

        tag = "sat_clr_race";
        cycle(1, 8388607, 0, 1, 0, 0, 0, 1, OMAX);
        chk("flag_race", longint'(sat_flag), 1);
        cycle(0, 0, 0, 1, 0, 0, 0, 0, 0);

        tag = "sat_neg";
        repeat (19) smp(-8388608, 0);
        smp_h(-8388608, 0, OMIN);
        chk("flag_neg", longint'(sat_flag), 1);

        tag = "rst_flush";
        for (int k = 0; k < TAPS; k++) wr(k, k + 1);
        repeat (16) smp(0, 0);

        tag = "rst_mid";
        smp_h(32768, 0, 1);
        for (int i = 1; i < 8; i++) smp_h(0, 0, i + 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_data", longint'(data_out), 0);
        chk("async_valid", longint'(out_valid), 0);
        chk("async_sat", longint'(sat_flag), 0);
        sb.delete();
        model_reset();
        #10;
        reset_n = 1'b1;

        tag = "post_rst";
        smp_h(32768, 0, 0);
        smp_h(0, 0, 0);
        idle(2);
        chk("drained", longint'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_transpose_cfg.md
Name: fir_transpose_cfg

Overview:
Parametrised, runtime-programmable transposed-form FIR filter. It is the successor to the fixed-coefficient transposed FIR in the audio/sine filtering chain.
- Adds a sample-valid qualifier, a coefficient write port, round-half-up scaling, output saturation with a sticky flag, and a bypass mode.
- Sits between the sample source (ADC/hex stimulus) and the output sink, and keeps the same clk/reset_n/data_in/data_out naming.

Parameters:
WD_IN, 24, signed input sample width
WD_OUT, 24, signed output sample width
WD_COEF, 16, signed coefficient width
TAPS, 16, number of taps (>=2)
FRAC, 15, fractional bits of coefficients (1<=FRAC<WD_COEF)
WD_ACC, WD_IN+WD_COEF+$clog2(TAPS), internal accumulator width (derived, not overridden)

Ports:
clk  in  1  clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
data_in  in  WD_IN  signed input sample
in_valid  in  1  data_in is a new sample this cycle
data_out  out  WD_OUT  signed filtered sample
out_valid  out  1  one-cycle pulse: data_out updated
coef_we  in  1  coefficient write strobe
coef_addr  in  $clog2(TAPS)  tap index to write
coef_data  in  WD_COEF  signed coefficient value
bypass  in  1  1: data_out follows data_in, filter unused for output
sat_flag  out  1  sticky: saturation has occurred
sat_clr  in  1  clears sat_flag

Behaviour:
- Reset (async assert, sync release) clears the following to 0:
  - all coefficients h[0..TAPS-1];
  - all partial-sum registers z[1..TAPS-1];
  - data_out, out_valid and sat_flag.
- Reset mid-stream discards all history. The first post-reset sample sees zero history and zero coefficients, so the output is 0 until coefficients are written.
- Transposed structure, updated only on a cycle with in_valid=1, using x = data_in:
  - p[k] = x*h[k], full precision;
  - z[k] <= p[k] + z[k+1] for 1<=k<TAPS-1;
  - z[TAPS-1] <= p[TAPS-1];
  - acc = p[0] + z[1], computed combinationally in WD_ACC.
- When in_valid=0, z, data_out and sat_flag hold, and out_valid=0. Gaps of any length between samples have no effect on the result.
- Scaling: r = (acc + 2^(FRAC-1)) >>> FRAC, an arithmetic shift, so halves round toward +inf.
- Saturation:
  - If r > 2^(WD_OUT-1)-1, the output is that maximum value.
  - If r < -2^(WD_OUT-1), the output is that minimum value.
  - Either case sets the saturation event for that sample.
- Latency is 1 clock. On the edge where in_valid=1 is sampled, data_out is loaded and out_valid goes to 1 for exactly one cycle.
  - Back-to-back in_valid gives a continuous out_valid.
- Bypass=1 on a valid cycle:
  - data_out <= data_in, sign-extended or saturated to WD_OUT.
  - Latency, out_valid and z updates are unchanged, so filter history stays current and clearing bypass needs no flush.
  - Bypass never sets sat_flag.
- Coefficient write: on coef_we=1, h[coef_addr] <= coef_data. Writes with coef_addr >= TAPS are ignored.
  - If coef_we and in_valid occur in the same cycle, the sample uses the old coefficient. The new value applies from the next valid sample.
  - Writes are allowed while streaming. No automatic history flush.
- sat_flag:
  - Set on any non-bypass sample that saturates.
  - Cleared by sat_clr.
  - If sat_clr and a saturation event occur in the same cycle, set wins and the flag stays 1.
- No internal overflow of acc is possible for any input or coefficient values, because WD_ACC includes the log2(TAPS) guard bits.

Test Plan:
- Impulse response:
  - Stimulus: write h[k]=k+1 for k=0..15; feed x=32768 (1.0 at FRAC=15) then 20 zero samples, all with in_valid=1.
  - Required: data_out = 1,2,...,16 then 0, each one cycle after its input, with out_valid high throughout.
- Rounding:
  - Stimulus: h[0]=16384 (0.5), other taps 0; feed x=3, then x=-3, then x=1.
  - Required: outputs 2, -1, 1 (1.5 rounds to 2, -1.5 to -1, 0.5 to 1).
- Saturation and sticky flag:
  - Stimulus: all h=32767, constant x=8388607; then pulse sat_clr; then repeat with x=-8388608.
  - Required: output clamps at 8388607 and sat_flag=1 and stays 1. sat_clr with no new saturation event clears it. The negative run clamps at -8388608 and sets sat_flag again.
  - Also assert sat_clr on the same cycle as a saturating sample: sat_flag must stay 1.
- Valid gaps and coefficient hazard:
  - Stimulus: impulse test with in_valid=0 for 3 cycles between every sample.
  - Required: same output sequence as the impulse test, out_valid only one cycle after each valid sample, data_out held between samples.
  - Also write h[0]=0 on the same cycle as the impulse: the impulse output still equals the old h[0]=1.
- Bypass and history continuity:
  - Stimulus: program the impulse coefficients; feed the impulse with bypass=1, then set bypass=0 two samples later.
  - Required: the first two outputs are 32768 and 0. The next outputs continue from 3,4,..., proving history was kept.
- Reset mid-stream:
  - Stimulus: assert reset_n=0 asynchronously halfway through the impulse response.
  - Required: data_out, out_valid and sat_flag go to 0 immediately, without waiting for a clock edge. After release, x=32768 produces 0 because coefficients were cleared.
